wb_ram_slave: RTL and testbench

Wishbone B3 slave RAM that responds to the CPU's external bus port (the `O_WB_*` / `I_WB_*` signals of the SoC top level). It is the target end of that initiator for simulation and FPGA builds. It supports classic single cycles with programmable wait states and incrementing bursts, `CTI=010` terminated by `CTI=111`, with byte-lane writes. Its address window is decoded outside; this block sees only the low address bits and aliases modulo its size.

---
 rtl/wb_ram_slave.sv | 82 ++++++++
 tb/tb_wb_ram_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B3 RAM target with programmable wait states, linear incrementing bursts and byte-lane writes.
module wb_ram_slave #(
   parameter int SIZE_BYTES  = 4096,
   parameter int WAIT_STATES = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic [31:0] i_wb_adr,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_dat,
   input  logic [2:0]  i_wb_cti,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_dat
);
   localparam int AW = $clog2(SIZE_BYTES) - 2;
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;
   state_t state;
   logic [3:0] wcnt;
   logic [AW-1:0] idx, nidx, aidx;
   logic [31:0] mem [0:(1<<AW)-1];
   logic beat, wr, unused;
   assign aidx = i_wb_adr[AW+1:2];
   assign nidx = idx + 1'b1;
   assign beat = o_wb_ack & i_wb_cyc & i_wb_stb;
   assign wr = beat & i_wb_we & ~i_reset;
   assign unused = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};
   always_ff @(posedge i_clk)
      for (int n = 0; n < 4; n++)
         if (wr && i_wb_sel[n]) mem[idx][8*n +: 8] <= i_wb_dat[8*n +: 8];
   // ACK and BURST share beat handling: cti=010 keeps acking the next word, anything else ends the cycle
   always_ff @(posedge i_clk)
      if (i_reset) begin
         state <= IDLE;
         o_wb_ack <= 1'b0;
         o_wb_dat <= '0;
         wcnt <= '0;
         idx <= '0;
      end else
         case (state)
            IDLE:
               if (i_wb_cyc && i_wb_stb) begin
                  idx <= aidx;
                  wcnt <= WS;
                  if (WS == 4'd0) begin
                     state <= ACK;
                     o_wb_ack <= 1'b1;
                     o_wb_dat <= mem[aidx];
                  end else
                     state <= WAIT;
               end
            WAIT:
               if (!i_wb_cyc)
                  state <= IDLE;
               else begin
                  wcnt <= wcnt - 1'b1;
                  if (wcnt == 4'd1) begin
                     state <= ACK;
                     o_wb_ack <= 1'b1;
                     o_wb_dat <= mem[idx];
                  end
               end
            ACK, BURST:
               if (!i_wb_cyc) begin
                  state <= IDLE;
                  o_wb_ack <= 1'b0;
               end else if (i_wb_stb) begin
                  if (i_wb_cti == 3'b010) begin
                     state <= BURST;
                     idx <= nidx;
                     o_wb_dat <= mem[nidx];
                  end else begin
                     state <= IDLE;
                     o_wb_ack <= 1'b0;
                  end
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: vectors, corner sequences and random transfers on a WS=1 and a WS=0 instance against a word-array model.
module tb_wb_ram_slave;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, cyc, stb, we, ack_a, ack_b, ack;
   logic [31:0] adr, wdat, dat_a, dat_b, dat;
   logic [3:0] sel;
   logic [2:0] cti;
   int u = 0;
   int checks = 0, errors = 0;
   logic [31:0] mdl [2][1024];
   logic [31:0] vm [2][1024];
   logic [31:0] bd [16];
   logic [31:0] rd [16];
   int at [16];
   assign ack = (u == 1) ? ack_b : ack_a;
   assign dat = (u == 1) ? dat_b : dat_a;
   wb_ram_slave #(.SIZE_BYTES(4096), .WAIT_STATES(1)) dut_a (
      .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc && u == 0), .i_wb_stb(stb), .i_wb_adr(adr),
      .i_wb_we(we), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti), .o_wb_ack(ack_a), .o_wb_dat(dat_a));
   wb_ram_slave #(.SIZE_BYTES(4096), .WAIT_STATES(0)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc && u == 1), .i_wb_stb(stb), .i_wb_adr(adr),
      .i_wb_we(we), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti), .o_wb_ack(ack_b), .o_wb_dat(dat_b));
   typedef struct {
      int u;
      bit w;
      logic [31:0] adr;
      logic [3:0] sel;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t tv [11];
   function automatic int ws();
      return (u == 1) ? 0 : 1;
   endfunction
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask
   task automatic put(input int i, input logic [31:0] d, input logic [3:0] s);
      for (int k = 0; k < 4; k++)
         if (s[k]) begin
            mdl[u][i][8*k +: 8] = d[8*k +: 8];
            vm[u][i][8*k +: 8] = 8'hff;
         end
   endtask
   // Runs one classic cycle (n=1) or an n-beat burst; starts and ends at a falling edge.
   task automatic xfer(input bit w, input logic [31:0] base, input int n, input logic [3:0] s,
                       input logic [2:0] last_cti, input int stall_at, input bit hold);
      int b = 0, t = 0, sl = 0;
      cyc = 1; stb = 1; we = w; adr = base; sel = s; wdat = bd[0];
      cti = (n == 1) ? last_cti : 3'b010;
      while (b < n && t < 40) begin
         @(negedge clk);
         t++;
         if (!stb) chk("stall_ack", {31'b0, ack}, 32'd1);
         if (ack && stb) begin
            rd[b] = dat;
            at[b] = t;
            if (w) put((int'(base[11:2]) + b) % 1024, bd[b], s);
            if (b == stall_at) sl = 2;
            b++;
         end
         @(posedge clk);
         #1;
         if (b < n) begin
            cti = (b == n - 1) ? last_cti : 3'b010;
            wdat = bd[b];
            stb = (sl == 0);
            if (sl > 0) sl--;
         end
      end
      chk("beats_done", b, n);
      if (!hold) begin
         cyc = 0; stb = 0; we = 0; cti = 0;
      end
      @(negedge clk);
      chk("ack_low_after", {31'b0, ack}, 32'd0);
   endtask
   task automatic mread(input string name, input logic [31:0] base, input int n);
      int i;
      for (int b = 0; b < n; b++) begin
         i = (int'(base[11:2]) + b) % 1024;
         chk(name, rd[b] & vm[u][i], mdl[u][i] & vm[u][i]);
      end
   endtask
   // Write burst interrupted at beat 2 by a cyc drop or by reset.
   task automatic abort(input bit by_rst, input logic [31:0] base);
      int t = 0;
      u = 0;
      bd[0] = 32'h0BAD_F00D;
      xfer(1, base + 4, 1, 4'hf, 3'b000, -1, 0);
      cyc = 1; stb = 1; we = 1; adr = base; sel = 4'hf; cti = 3'b010; wdat = 32'h1111_0000 + base;
      do begin
         @(negedge clk);
         t++;
      end while (!ack && t < 10);
      chk("abort_first_lat", t, 2);
      @(posedge clk);
      #1;
      put(int'(base[11:2]), 32'h1111_0000 + base, 4'hf);
      wdat = 32'h2222_2222;
      @(negedge clk);
      chk("abort_beat2_ack", {31'b0, ack}, 32'd1);
      if (by_rst) rst = 1;
      else begin
         cyc = 0; stb = 0; we = 0;
      end
      @(negedge clk);
      chk("abort_ack", {31'b0, ack}, 32'd0);
      if (by_rst) chk("abort_rst_dat", dat, 32'd0);
      rst = 0; cyc = 0; stb = 0; we = 0; cti = 0;
      xfer(0, base + 4, 1, 4'hf, 3'b000, -1, 0);
      chk("abort_fresh_lat", at[0], 2);
      chk("abort_beat2_kept", rd[0], 32'h0BAD_F00D);
      xfer(0, base, 1, 4'hf, 3'b000, -1, 0);
      chk("abort_beat1_written", rd[0], 32'h1111_0000 + base);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int n, word;
      bit w;
      logic [31:0] base;
      for (int j = 0; j < 2; j++)
         for (int i = 0; i < 1024; i++) begin
            mdl[j][i] = 0;
            vm[j][i] = 0;
         end
      rst = 1; cyc = 1; stb = 1; we = 0; adr = 0; sel = 4'hf; wdat = 0; cti = 0;
      repeat (3) begin
         @(negedge clk);
         chk("reset_ack", {31'b0, ack_a}, 32'd0);
         chk("reset_dat", dat_a, 32'd0);
      end
      rst = 0;
      xfer(0, 32'h0, 1, 4'hf, 3'b000, -1, 0);
      chk("reset_first_lat", at[0], 2);
      tv[0]  = '{0, 1, 32'h10,   4'hf, 32'hDEAD_BEEF, 32'h0};
      tv[1]  = '{0, 1, 32'h10,   4'h4, 32'h00AA_0000, 32'h0};
      tv[2]  = '{0, 0, 32'h10,   4'hf, 32'h0,         32'hDEAA_BEEF};
      tv[3]  = '{0, 1, 32'h14,   4'h3, 32'h1234_5678, 32'h0};
      tv[4]  = '{0, 1, 32'h14,   4'hc, 32'h9ABC_DEF0, 32'h0};
      tv[5]  = '{0, 0, 32'h14,   4'hf, 32'h0,         32'h9ABC_5678};
      tv[6]  = '{0, 1, 32'h1018, 4'hf, 32'hA5A5_A5A5, 32'h0};
      tv[7]  = '{0, 0, 32'h18,   4'h0, 32'h0,         32'hA5A5_A5A5};
      tv[8]  = '{1, 1, 32'h10,   4'hf, 32'hCAFE_F00D, 32'h0};
      tv[9]  = '{1, 0, 32'h10,   4'hf, 32'h0,         32'hCAFE_F00D};
      tv[10] = '{0, 0, 32'h10,   4'hf, 32'h0,         32'hDEAA_BEEF};
      for (int i = 0; i < 11; i++) begin
         u = tv[i].u;
         bd[0] = tv[i].d;
         xfer(tv[i].w, tv[i].adr, 1, tv[i].sel, 3'b000, -1, 0);
         chk("vec_lat", at[0], ws() + 1);
         if (!tv[i].w) chk("vec_rd", rd[0], tv[i].exp);
      end
      u = 0;
      for (int b = 0; b < 4; b++) bd[b] = b + 1;
      xfer(1, 32'h20, 4, 4'hf, 3'b111, -1, 0);
      for (int b = 0; b < 4; b++) chk("wburst_ack_cycle", at[b], 2 + b);
      xfer(0, 32'h2C, 1, 4'hf, 3'b000, -1, 0);
      chk("wburst_read_2c", rd[0], 32'd4);
      bd[0] = 32'h1111_1111; xfer(1, 32'hFF8, 1, 4'hf, 3'b000, -1, 0);
      bd[0] = 32'h2222_2222; xfer(1, 32'hFFC, 1, 4'hf, 3'b000, -1, 0);
      bd[0] = 32'h3333_3333; xfer(1, 32'h000, 1, 4'hf, 3'b000, -1, 0);
      xfer(0, 32'hFF8, 3, 4'hf, 3'b111, 0, 0);
      chk("wrap_d0", rd[0], 32'h1111_1111);
      chk("wrap_d1", rd[1], 32'h2222_2222);
      chk("wrap_d2", rd[2], 32'h3333_3333);
      chk("wrap_t0", at[0], 2);
      chk("wrap_t1", at[1], 5);
      chk("wrap_t2", at[2], 6);
      abort(0, 32'h40);
      abort(1, 32'h50);
      u = 1;
      for (int i = 0; i < 3; i++) begin
         xfer(0, 32'h10, 1, 4'hf, 3'b000, -1, i < 2);
         chk("ws0_lat", at[0], 1);
         chk("ws0_rd", rd[0], 32'hCAFE_F00D);
      end
      for (int j = 0; j < 2; j++) begin
         u = j;
         for (int b = 0; b < 16; b++) bd[b] = $urandom;
         xfer(1, 32'h0, 16, 4'hf, 3'b111, -1, 0);
         for (int b = 0; b < 4; b++) bd[b] = $urandom;
         xfer(1, 32'hFF0, 4, 4'hf, 3'b000, -1, 0);
      end
      for (int r = 0; r < 80; r++) begin
         u = $urandom_range(0, 1);
         n = $urandom_range(1, 5);
         w = 1'($urandom_range(0, 1));
         word = ($urandom_range(0, 3) == 0) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, 15);
         base = 32'(word * 4 + 4096 * $urandom_range(0, 3));
         for (int b = 0; b < n; b++) bd[b] = $urandom;
         xfer(w, base, n, w ? 4'($urandom) : 4'hf,
              (n == 1 || $urandom_range(0, 1) == 0) ? 3'b000 : 3'b111, -1, 0);
         for (int b = 0; b < n; b++) chk("rnd_ack_cycle", at[b], ws() + 1 + b);
         if (!w) mread("rnd_rd", base, n);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
